// File: rtl/spike_window_decoder_if.sv
// Result channel of spike_window_decoder.
// The decoder drives this through the master modport. The consumer uses the
// slave modport.
//   out_valid   master->slave  a window result is being presented
//   out_ready   slave->master  the consumer accepts the result this cycle
//   out_winner  master->slave  index of the channel with the highest count
//   out_count   master->slave  spike count of the winning channel
//   out_none    master->slave  every channel counted zero in the window
//   out_total   master->slave  sum of all channel counts; this signal exists
//                              only when SPIKE_DEC_TOTAL_EN is defined
interface spike_window_decoder_if #(
   parameter int N_CH  = 8,
   parameter int CNT_W = 8
);
   localparam int IDX_W = $clog2(N_CH);

   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_winner;
   logic [CNT_W-1:0] out_count;
   logic             out_none;
`ifdef SPIKE_DEC_TOTAL_EN
   logic [CNT_W+IDX_W-1:0] out_total;

   modport master (output out_valid, out_winner, out_count, out_none, out_total,
                   input  out_ready);
   modport slave  (input  out_valid, out_winner, out_count, out_none, out_total,
                   output out_ready);
`else
   modport master (output out_valid, out_winner, out_count, out_none,
                   input  out_ready);
   modport slave  (input  out_valid, out_winner, out_count, out_none,
                   output out_ready);
`endif
endinterface

// File: rtl/spike_window_decoder.sv
// spike_window_decoder
// This block counts spikes per channel over a fixed window of WINDOW cycles.
// At the end of each window it snapshots the counts. It then scans the
// snapshot one channel per cycle to find the channel with the highest count.
// Ties go to the lowest index. The result is presented on a valid/ready
// handshake.
//
// Optional feature, controlled by the macro SPIKE_DEC_TOTAL_EN:
//   When defined, the scan also sums all snapshot counts and presents the sum
//   on out_if.out_total.
//
// Ports:
//   clk      clock
//   rst      synchronous, active-high reset
//   spikes   one bit per channel, sampled every cycle
//   out_if   result channel (master modport of spike_window_decoder_if)
//   overrun  sticky flag: a window ended while a result was still pending,
//            and that window's snapshot was dropped
//
// State | meaning
// IDLE  | no pending result; the next window end starts a scan
// SCAN  | walking the snapshot one channel per cycle
// VALID | result presented; waiting for out_ready
module spike_window_decoder #(
   parameter int N_CH   = 8,
   parameter int WINDOW = 64,
   parameter int CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       spikes,
   spike_window_decoder_if.master out_if,
   output logic                  overrun
);
   localparam int IDX_W = $clog2(N_CH);
   localparam int WC_W  = $clog2(WINDOW);
   localparam int TOT_W = CNT_W + IDX_W;
   localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WINDOW - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

   typedef enum logic [1:0] {IDLE, SCAN, VALID} state_t;

   state_t           state;
   logic [CNT_W-1:0] live     [N_CH];
   logic [CNT_W-1:0] live_nxt [N_CH];
   logic [CNT_W-1:0] shadow   [N_CH];
   logic [WC_W-1:0]  wcnt;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] best_idx;
   logic [CNT_W-1:0] best;
   logic             win_end;
   logic [CNT_W-1:0] cand;
   logic             take;
   logic [CNT_W-1:0] best_nxt;
   logic [IDX_W-1:0] best_idx_nxt;

   logic             valid_q;
   logic [IDX_W-1:0] winner_q;
   logic [CNT_W-1:0] count_q;
   logic             none_q;
`ifdef SPIKE_DEC_TOTAL_EN
   logic [TOT_W-1:0] total_acc;
   logic [TOT_W-1:0] total_q;
`endif

   // Each live counter saturates instead of wrapping.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         live_nxt[i] = live[i];
         if (spikes[i] && (live[i] != {CNT_W{1'b1}}))
            live_nxt[i] = live[i] + 1'b1;
      end
   end

   assign win_end = (wcnt == WC_LAST);
   assign cand    = shadow[idx];
   // Replace only on strictly greater, so ties keep the lower index.
   assign take         = (cand > best);
   assign best_nxt     = take ? cand : best;
   assign best_idx_nxt = take ? idx  : best_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            live[i]   <= '0;
            shadow[i] <= '0;
         end
         wcnt     <= '0;
         state    <= IDLE;
         idx      <= '0;
         best     <= '0;
         best_idx <= '0;
         valid_q  <= 1'b0;
         winner_q <= '0;
         count_q  <= '0;
         none_q   <= 1'b0;
         overrun  <= 1'b0;
`ifdef SPIKE_DEC_TOTAL_EN
         total_acc <= '0;
         total_q   <= '0;
`endif
      end else begin
         // Counting runs regardless of FSM state. The final sample of a
         // window goes into the snapshot, not into the new window.
         if (win_end) begin
            wcnt <= '0;
            for (int i = 0; i < N_CH; i++) live[i] <= '0;
         end else begin
            wcnt <= wcnt + 1'b1;
            for (int i = 0; i < N_CH; i++) live[i] <= live_nxt[i];
         end

         if (win_end && (state != IDLE)) overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (win_end) begin
                  for (int i = 0; i < N_CH; i++) shadow[i] <= live_nxt[i];
                  // best starts at 0 rather than shadow[0]. Scan step 0 then
                  // takes shadow[0] whenever it is nonzero. This is equivalent
                  // and avoids reading the snapshot in the same cycle it is
                  // loaded.
                  idx      <= '0;
                  best     <= '0;
                  best_idx <= '0;
`ifdef SPIKE_DEC_TOTAL_EN
                  total_acc <= '0;
`endif
                  state    <= SCAN;
               end
            end
            SCAN: begin
               best     <= best_nxt;
               best_idx <= best_idx_nxt;
               idx      <= idx + 1'b1;
`ifdef SPIKE_DEC_TOTAL_EN
               total_acc <= total_acc + TOT_W'(cand);
`endif
               if (idx == IDX_LAST) begin
                  state    <= VALID;
                  valid_q  <= 1'b1;
                  winner_q <= best_idx_nxt;
                  count_q  <= best_nxt;
                  none_q   <= (best_nxt == '0);
`ifdef SPIKE_DEC_TOTAL_EN
                  total_q  <= total_acc + TOT_W'(cand);
`endif
               end
            end
            VALID: begin
               if (out_if.out_ready) begin
                  valid_q <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign out_if.out_valid  = valid_q;
   assign out_if.out_winner = winner_q;
   assign out_if.out_count  = count_q;
   assign out_if.out_none   = none_q;
`ifdef SPIKE_DEC_TOTAL_EN
   assign out_if.out_total  = total_q;
`endif
endmodule

// File: tb/tb_spike_window_decoder.sv
// Bench for spike_window_decoder.
// Two instances, with CNT_W=8 and CNT_W=3, receive identical stimulus.
// Stimulus is built per episode, and every episode starts from reset. A
// window-level model turns each episode's stimulus into expected results,
// delivery cycles and the overrun onset. A monitor checks the outputs of both
// instances against the expected queue on every falling edge.
module tb_spike_window_decoder;
   localparam int N_CH   = 8;
   localparam int WINDOW = 16;
   localparam int MAXLEN = 256;

   typedef struct {
      int vcyc;
      int acyc;
      int w8;
      int c8;
      int t8;
      int w3;
      int c3;
      int t3;
      int none;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] spikes;
   logic       ready;
   logic       ov8;
   logic       ov3;

   always #5 clk = ~clk;

   spike_window_decoder_if #(.N_CH(N_CH), .CNT_W(8)) rif8 ();
   spike_window_decoder_if #(.N_CH(N_CH), .CNT_W(3)) rif3 ();

   assign rif8.out_ready = ready;
   assign rif3.out_ready = ready;

   spike_window_decoder #(.N_CH(N_CH), .WINDOW(WINDOW), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .spikes(spikes), .out_if(rif8), .overrun(ov8));
   spike_window_decoder #(.N_CH(N_CH), .WINDOW(WINDOW), .CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .spikes(spikes), .out_if(rif3), .overrun(ov3));

   logic [7:0] sp_a [MAXLEN];
   bit         rd_a [MAXLEN];
   exp_t       exp_q [$];
   int         cyc;
   int         ov_from;
   int         lost;
   bit         mon_en = 1'b0;
   int         errors = 0;
   int         checks = 0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic void best_of(input int cnt [N_CH], input int cap,
                                   output int w, output int m, output int tot);
      m = -1; w = 0; tot = 0;
      for (int ch = 0; ch < N_CH; ch++) begin
         int c;
         c = (cnt[ch] > cap) ? cap : cnt[ch];
         tot += c;
         if (c > m) begin m = c; w = ch; end
      end
   endfunction

   // Window-level model. A window ending in cycle e is reported from
   // e+N_CH+1 and accepted at the first later cycle with ready high. If a
   // window ends while an earlier result is not yet accepted (up to and
   // including its accept cycle), that window is dropped and overrun rises
   // in the following cycle.
   function automatic void build_expected(input int len);
      int busy_until;
      busy_until = -1;
      ov_from = 1 << 30;
      lost = 0;
      for (int e = WINDOW - 1; e < len; e += WINDOW) begin
         int   cnt [N_CH];
         exp_t x;
         int   c;
         for (int ch = 0; ch < N_CH; ch++) cnt[ch] = 0;
         for (int t = e - WINDOW + 1; t <= e; t++)
            for (int ch = 0; ch < N_CH; ch++)
               cnt[ch] += int'(sp_a[t][ch]);
         if (e <= busy_until) begin
            if (ov_from > e + 1) ov_from = e + 1;
            continue;
         end
         best_of(cnt, 255, x.w8, x.c8, x.t8);
         best_of(cnt, 7,   x.w3, x.c3, x.t3);
         x.none = (x.c8 == 0) ? 1 : 0;
         x.vcyc = e + N_CH + 1;
         c = -1;
         for (int t = x.vcyc; t < len; t++)
            if (rd_a[t]) begin c = t; break; end
         x.acyc = c;
         exp_q.push_back(x);
         if (c < 0) begin
            lost = 1;
            busy_until = 1 << 30;
         end else begin
            busy_until = c;
         end
      end
   endfunction

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         int exp_valid;
         if (cyc == 0) begin
            chk("rst_winner8", int'(rif8.out_winner), 0);
            chk("rst_count8",  int'(rif8.out_count), 0);
            chk("rst_none8",   int'(rif8.out_none), 0);
            chk("rst_count3",  int'(rif3.out_count), 0);
         end
         chk("overrun8", int'(ov8), (cyc >= ov_from) ? 1 : 0);
         chk("overrun3", int'(ov3), (cyc >= ov_from) ? 1 : 0);
         exp_valid = (exp_q.size() > 0 && cyc >= exp_q[0].vcyc) ? 1 : 0;
         chk("valid8", int'(rif8.out_valid), exp_valid);
         chk("valid3", int'(rif3.out_valid), exp_valid);
         if (exp_valid == 1) begin
            exp_t x;
            x = exp_q[0];
            chk("winner8", int'(rif8.out_winner), x.w8);
            chk("count8",  int'(rif8.out_count),  x.c8);
            chk("none8",   int'(rif8.out_none),   x.none);
            chk("winner3", int'(rif3.out_winner), x.w3);
            chk("count3",  int'(rif3.out_count),  x.c3);
            chk("none3",   int'(rif3.out_none),   x.none);
`ifdef SPIKE_DEC_TOTAL_EN
            chk("total8",  int'(rif8.out_total),  x.t8);
            chk("total3",  int'(rif3.out_total),  x.t3);
`endif
            if (ready) exp_q.pop_front();
         end
      end
   end

   task automatic clear_stim();
      for (int t = 0; t < MAXLEN; t++) begin
         sp_a[t] = 8'h00;
         rd_a[t] = 1'b1;
      end
   endtask

   task automatic fill_random(input int ready_pct);
      int dens [N_CH];
      for (int ch = 0; ch < N_CH; ch++) dens[ch] = $urandom_range(0, 100);
      for (int t = 0; t < MAXLEN; t++) begin
         for (int ch = 0; ch < N_CH; ch++)
            sp_a[t][ch] = ($urandom_range(0, 99) < dens[ch]) ? 1'b1 : 1'b0;
         rd_a[t] = ($urandom_range(0, 99) < ready_pct) ? 1'b1 : 1'b0;
      end
   endtask

   // Runs cycles 0..len-1 with rst low, then holds rst high for cycle len.
   task automatic run_episode(input int len);
      build_expected(len);
      for (int k = 0; k < len; k++) begin
         cyc    = k;
         rst    = 1'b0;
         spikes = sp_a[k];
         ready  = rd_a[k];
         @(posedge clk); #1;
      end
      cyc    = len;
      rst    = 1'b1;
      ready  = 1'b0;
      spikes = 8'($urandom);
      @(posedge clk); #1;
      chk("undelivered", exp_q.size(), lost);
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1; ready = 1'b0; spikes = 8'h00; cyc = 0; ov_from = 1 << 30;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Channel 3 fires 5 times in window 0. Window 1 is silent.
      clear_stim();
      for (int k = 1; k <= 9; k += 2) sp_a[k] = 8'h08;
      run_episode(48);

      // Channels 2 and 6 tie with 4 spikes each.
      clear_stim();
      for (int k = 0; k < 4; k++) begin
         sp_a[k]     = 8'h04;
         sp_a[k + 8] = 8'h40;
      end
      run_episode(30);

      // Backpressure for 40 cycles after the first result.
      fill_random(100);
      for (int t = 0; t < MAXLEN; t++) rd_a[t] = 1'b1;
      for (int t = 24; t < 64; t++) rd_a[t] = 1'b0;
      run_episode(100);

      // Channel 0 fires every cycle. Channel 5 fires 10 times and ties
      // channel 0 once both are saturated at 7.
      clear_stim();
      for (int k = 0; k < WINDOW; k++) sp_a[k] = 8'h01;
      for (int k = 0; k < 10; k++) sp_a[k] = sp_a[k] | 8'h20;
      run_episode(30);

      // Reset in cycle 18 (mid scan), then a fresh window.
      fill_random(100);
      run_episode(18);
      fill_random(100);
      run_episode(40);

      for (int r = 0; r < 8; r++) begin
         fill_random($urandom_range(20, 100));
         run_episode($urandom_range(60, 200));
      end

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
